// File: rtl/washer_pkg.sv
// Shared definitions for the washing-machine controller, its plant model and benches.
package washer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILLING  = 3'd1,
        SHAKING  = 3'd2,
        SPINNING = 3'd3,
        FAULT    = 3'd4
    } phase_t;

    localparam int DEF_FILL_CYCLES  = 4;
    localparam int DEF_SHAKE_CYCLES = 6;
    localparam int DEF_DRY_CYCLES   = 3;
    localparam int DEF_CNT_W        = 4;

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at LIMIT on the way up and at zero on the way down.
module sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic         hold,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!hold) begin
            if (clr)
                count <= '0;
            else if (inc && count < LIM)
                count <= count + 1'b1;
            else if (dec && count != '0)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/washer_plant.sv
// Plant/sensor model for the washer controller: water level, agitation and dry timers,
// plus an absorbing fault state for illegal actuator sequences.
module washer_plant
    import washer_pkg::*;
#(
    parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
    parameter int SHAKE_CYCLES = DEF_SHAKE_CYCLES,
    parameter int DRY_CYCLES   = DEF_DRY_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valve,
    input  logic             shake_mode,
    input  logic             turn_mode,
    output logic             full,
    output logic             Time,
    output logic             dry,
    output logic [CNT_W-1:0] level,
    output logic [2:0]       phase,
    output logic             fault
);

    localparam logic [CNT_W-1:0] FILL_L  = CNT_W'(FILL_CYCLES);
    localparam logic [CNT_W-1:0] SHAKE_L = CNT_W'(SHAKE_CYCLES);
    localparam logic [CNT_W-1:0] DRY_L   = CNT_W'(DRY_CYCLES);

    phase_t           state, state_next;
    logic [CNT_W-1:0] shake_cnt, dry_cnt;
    logic             lvl_inc, lvl_dec, shk_inc, dry_inc, clr_all, freeze;
    logic             overlap;

    assign fault   = (state == FAULT);
    assign full    = (level == FILL_L) && !fault;
    assign Time    = (shake_cnt == SHAKE_L) && !fault;
    assign dry     = (level == '0) && (dry_cnt == DRY_L) && !fault;
    assign phase   = state;
    assign freeze  = fault;
    assign overlap = ($countones({valve, shake_mode, turn_mode}) > 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_next = state;
        lvl_inc    = 1'b0;
        lvl_dec    = 1'b0;
        shk_inc    = 1'b0;
        dry_inc    = 1'b0;
        clr_all    = 1'b0;
        if (state == FAULT) begin
            state_next = FAULT;
        end else if (overlap) begin
            state_next = FAULT;
        end else if (valve) begin
            if (state == IDLE || state == FILLING) begin
                state_next = FILLING;
                lvl_inc    = 1'b1;
            end else begin
                state_next = FAULT;
            end
        end else if (shake_mode) begin
            if ((state == FILLING && full) || state == SHAKING) begin
                state_next = SHAKING;
                shk_inc    = 1'b1;
            end else begin
                state_next = FAULT;
            end
        end else if (turn_mode) begin
            if ((state == SHAKING && Time) || state == SPINNING) begin
                state_next = SPINNING;
                // Drain first; the dry timer only runs once the tub is empty.
                if (level != '0) lvl_dec = 1'b1;
                else             dry_inc = 1'b1;
            end else begin
                state_next = FAULT;
            end
        end else if (state == SPINNING && dry) begin
            state_next = IDLE;
            clr_all    = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W), .LIMIT(FILL_CYCLES)) u_level (
        .clock (clock),
        .reset (reset),
        .inc   (lvl_inc),
        .dec   (lvl_dec),
        .clr   (clr_all),
        .hold  (freeze),
        .count (level)
    );

    sat_counter #(.W(CNT_W), .LIMIT(SHAKE_CYCLES)) u_shake (
        .clock (clock),
        .reset (reset),
        .inc   (shk_inc),
        .dec   (1'b0),
        .clr   (clr_all),
        .hold  (freeze),
        .count (shake_cnt)
    );

    sat_counter #(.W(CNT_W), .LIMIT(DRY_CYCLES)) u_dry (
        .clock (clock),
        .reset (reset),
        .inc   (dry_inc),
        .dec   (1'b0),
        .clr   (clr_all),
        .hold  (freeze),
        .count (dry_cnt)
    );

endmodule

// File: tb/tb_washer_plant.sv
// Directed scenarios plus randomized actuator traffic, compared every edge against a
// rule-level reference model of the plant.
module tb_washer_plant;
    import washer_pkg::*;

    localparam int FILL  = DEF_FILL_CYCLES;
    localparam int SHAKE = DEF_SHAKE_CYCLES;
    localparam int DRYC  = DEF_DRY_CYCLES;
    localparam int W     = DEF_CNT_W;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         valve = 1'b0, shake_mode = 1'b0, turn_mode = 1'b0;
    logic         full, Time, dry, fault;
    logic [W-1:0] level;
    logic [2:0]   phase;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: abstract phase plus plain integer counters.
    phase_t m_phase = IDLE;
    int     m_level = 0, m_shake = 0, m_dry = 0;

    washer_plant #(
        .FILL_CYCLES(FILL), .SHAKE_CYCLES(SHAKE), .DRY_CYCLES(DRYC), .CNT_W(W)
    ) dut (
        .clock(clock), .reset(reset), .valve(valve), .shake_mode(shake_mode),
        .turn_mode(turn_mode), .full(full), .Time(Time), .dry(dry),
        .level(level), .phase(phase), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int m_full();
        return int'(m_level == FILL && m_phase != FAULT);
    endfunction
    function automatic int m_time();
        return int'(m_shake == SHAKE && m_phase != FAULT);
    endfunction
    function automatic int m_dry_o();
        return int'(m_level == 0 && m_dry == DRYC && m_phase != FAULT);
    endfunction

    task automatic model_reset();
        m_phase = IDLE; m_level = 0; m_shake = 0; m_dry = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit t);
        int n_on;
        n_on = int'(v) + int'(s) + int'(t);
        if (m_phase == FAULT) return;
        if (n_on > 1) begin
            m_phase = FAULT;
        end else if (v) begin
            if (m_phase == IDLE || m_phase == FILLING) begin
                m_phase = FILLING; m_level = min2(m_level + 1, FILL);
            end else m_phase = FAULT;
        end else if (s) begin
            if ((m_phase == FILLING && m_full() == 1) || m_phase == SHAKING) begin
                m_phase = SHAKING; m_shake = min2(m_shake + 1, SHAKE);
            end else m_phase = FAULT;
        end else if (t) begin
            if ((m_phase == SHAKING && m_time() == 1) || m_phase == SPINNING) begin
                m_phase = SPINNING;
                if (m_level != 0) m_level = m_level - 1;
                else              m_dry = min2(m_dry + 1, DRYC);
            end else m_phase = FAULT;
        end else if (m_phase == SPINNING && m_dry_o() == 1) begin
            m_phase = IDLE; m_level = 0; m_shake = 0; m_dry = 0;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".full"},  int'(full),  m_full());
        check({ctx, ".Time"},  int'(Time),  m_time());
        check({ctx, ".dry"},   int'(dry),   m_dry_o());
        check({ctx, ".level"}, int'(level), m_level);
        check({ctx, ".phase"}, int'(phase), int'(m_phase));
        check({ctx, ".fault"}, int'(fault), int'(m_phase == FAULT));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit v, input bit s, input bit t);
        valve = v; shake_mode = s; turn_mode = t;
        @(posedge clock);
        model_step(v, s, t);
        #1 compare_all("step");
        @(negedge clock);
    endtask

    task automatic do_reset();
        valve = 1'b0; shake_mode = 1'b0; turn_mode = 1'b0;
        reset = 1'b1;
        model_reset();
        #1 compare_all("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Hold one command until the chosen sensor (0=full,1=Time,2=dry) rises; count edges.
    task automatic run_until(input bit v, input bit s, input bit t, input int which,
                             output int edges);
        bit hit;
        edges = 0;
        hit   = 1'b0;
        while (!hit && edges < 20) begin
            cycle(v, s, t);
            edges++;
            hit = (which == 0) ? full : (which == 1) ? Time : dry;
        end
        if (!hit) check("run_until_timeout", edges, -1);
    endtask

    task automatic nominal_wash(input string tag);
        int e;
        run_until(1, 0, 0, 0, e); check({tag, ".fill_edges"},  e, FILL);
        run_until(0, 1, 0, 1, e); check({tag, ".shake_edges"}, e, SHAKE);
        run_until(0, 0, 1, 2, e); check({tag, ".dry_edges"},   e, FILL + DRYC);
        cycle(0, 0, 0);
        check({tag, ".back_idle"},  int'(phase), 0);
        check({tag, ".level_zero"}, int'(level), 0);
    endtask

    task automatic natural_cmd();
        case (m_phase)
            IDLE:     cycle(1, 0, 0);
            FILLING:  if (m_level == FILL && $urandom_range(0, 3) != 0) cycle(0, 1, 0);
                      else cycle(1, 0, 0);
            SHAKING:  if (m_shake == SHAKE && $urandom_range(0, 3) != 0) cycle(0, 0, 1);
                      else cycle(0, 1, 0);
            SPINNING: cycle(0, 0, 1);
            default:  cycle(0, 0, 0);
        endcase
    endtask

    initial begin
        int e;
        logic [2:0] bits;
        int r;

        repeat (2) @(negedge clock);
        do_reset();
        check("reset.full", int'(full), 0);
        check("reset.phase", int'(phase), 0);

        // Two back-to-back washes with identical timing.
        nominal_wash("wash1");
        nominal_wash("wash2");

        // Pause and saturation during fill.
        do_reset();
        repeat (2) cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        check("pause.level", int'(level), 2);
        run_until(1, 0, 0, 0, e); check("pause.fill_rest", e, 2);
        repeat (3) cycle(1, 0, 0);
        check("sat.level", int'(level), FILL);
        check("sat.full",  int'(full), 1);

        // Overlapping commands.
        do_reset();
        cycle(1, 1, 0);
        check("overlap.fault", int'(fault), 1);
        check("overlap.phase", int'(phase), 4);
        repeat (3) cycle(1, 0, 0);
        check("overlap.sticky", int'(fault), 1);
        check("overlap.level",  int'(level), 0);

        // Out-of-order steps.
        do_reset();
        repeat (2) cycle(1, 0, 0);
        cycle(0, 1, 0);
        check("early_shake.fault", int'(fault), 1);
        do_reset();
        cycle(0, 0, 1);
        check("idle_turn.fault", int'(fault), 1);

        // Reset in the middle of agitation.
        do_reset();
        repeat (FILL) cycle(1, 0, 0);
        repeat (3) cycle(0, 1, 0);
        do_reset();
        check("midrst.level", int'(level), 0);
        cycle(1, 0, 0);
        check("midrst.refill", int'(level), 1);

        // Early spin exit and resume.
        do_reset();
        repeat (FILL) cycle(1, 0, 0);
        repeat (SHAKE) cycle(0, 1, 0);
        repeat (FILL - 1) cycle(0, 0, 1);
        repeat (2) cycle(0, 0, 0);
        check("spin_pause.phase", int'(phase), 3);
        check("spin_pause.level", int'(level), 1);
        check("spin_pause.dry",   int'(dry), 0);
        run_until(0, 0, 1, 2, e); check("spin_resume.edges", e, 1 + DRYC);

        // Randomized traffic, mostly legal progress with pauses, stray commands and resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 8 || (m_phase == FAULT && r < 150)) begin
                do_reset();
            end else if (r < 30) begin
                bits = 3'($urandom_range(0, 7));
                cycle(bits[2], bits[1], bits[0]);
            end else if (r < 230) begin
                cycle(0, 0, 0);
            end else begin
                natural_cmd();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
